// File: rtl/snake_pkg.sv
// Shared encodings, field geometry and reset coordinates for the snake game core.
package snake_pkg;

    localparam int SEG_W        = 11;
    localparam int MAX_SEGMENTS = 23;
    localparam int GRID         = 32;

    localparam logic [SEG_W-1:0] X_MIN = 11'd16;
    localparam logic [SEG_W-1:0] X_MAX = 11'd1392;
    localparam logic [SEG_W-1:0] Y_MIN = 11'd16;
    localparam logic [SEG_W-1:0] Y_MAX = 11'd848;

    localparam logic [SEG_W-1:0] RST_X0 = 11'd688;
    localparam logic [SEG_W-1:0] RST_X1 = 11'd656;
    localparam logic [SEG_W-1:0] RST_X2 = 11'd624;
    localparam logic [SEG_W-1:0] RST_Y  = 11'd432;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_COMMIT = 3'd3,
        ST_DEAD   = 3'd4,
        ST_WON    = 3'd5
    } state_e;

    function automatic dir_e opposite_dir(input dir_e d);
        case (d)
            DIR_UP:    return DIR_DOWN;
            DIR_DOWN:  return DIR_UP;
            DIR_LEFT:  return DIR_RIGHT;
            DIR_RIGHT: return DIR_LEFT;
            default:   return DIR_LEFT;
        endcase
    endfunction

endpackage

// File: rtl/snake_engine_collide.sv
// Combinational collision checks for a candidate head cell against field, wall, apple and body.
module snake_collide
    import snake_pkg::*;
#(
    parameter int MAX_SEG = MAX_SEGMENTS
) (
    input  logic [SEG_W-1:0]         cand_x,
    input  logic [SEG_W-1:0]         cand_y,
    input  logic [MAX_SEG*SEG_W-1:0] seg_x,
    input  logic [MAX_SEG*SEG_W-1:0] seg_y,
    input  logic [5:0]               length,
    input  logic [SEG_W-1:0]         apple_x,
    input  logic [SEG_W-1:0]         apple_y,
    input  logic [SEG_W-1:0]         wall_x,
    input  logic [SEG_W-1:0]         wall_y,
    output logic                     border,
    output logic                     wall,
    output logic                     self_hit,
    output logic                     eat
);

    // Underflow past the top/left edge wraps high and is caught by the upper bound.
    always_comb begin
        border   = (cand_x < X_MIN) || (cand_x > X_MAX) || (cand_y < Y_MIN) || (cand_y > Y_MAX);
        wall     = (cand_x == wall_x) && (cand_y == wall_y);
        eat      = (cand_x == apple_x) && (cand_y == apple_y);
        self_hit = 1'b0;
        for (int i = 1; i < MAX_SEG; i++) begin
            self_hit = self_hit
                     | ((seg_x[i*SEG_W +: SEG_W] == cand_x) && (seg_y[i*SEG_W +: SEG_W] == cand_y)
                        && ((i < int'(length) - 1) || (eat && (i == int'(length) - 1))));
        end
    end

endmodule

// File: rtl/snake_engine.sv
// Snake game-state core: direction input, tick-driven moves, collision/eat handling, win/lose.
module snake_engine #(
    parameter int MAX_SEGMENTS = snake_pkg::MAX_SEGMENTS,
    parameter int WIN_LEN      = 23,
    parameter int INIT_LEN     = 3,
    parameter int GRID         = snake_pkg::GRID
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        tick,
    input  logic                        btn_up,
    input  logic                        btn_down,
    input  logic                        btn_left,
    input  logic                        btn_right,
    input  logic [10:0]                 applepos_x,
    input  logic [10:0]                 applepos_y,
    input  logic [10:0]                 wallpos_x,
    input  logic [10:0]                 wallpos_y,
    output logic [MAX_SEGMENTS*11-1:0]  snakepos_x,
    output logic [MAX_SEGMENTS*11-1:0]  snakepos_y,
    output logic [5:0]                  length,
    output logic [1:0]                  head_dir,
    output logic                        apple_eaten,
    output logic                        lose,
    output logic                        win
);
    import snake_pkg::*;

    localparam int BUS_W = MAX_SEGMENTS * SEG_W;
    localparam logic [BUS_W-1:0] RST_BUS_X = BUS_W'({RST_X2, RST_X1, RST_X0});
    localparam logic [BUS_W-1:0] RST_BUS_Y = BUS_W'({RST_Y, RST_Y, RST_Y});

    state_e            state_q, state_d;
    dir_e              pending_dir_q, pending_dir_d;
    dir_e              head_dir_q, head_dir_d;
    logic [5:0]        length_q, length_d;
    logic [BUS_W-1:0]  seg_x_q, seg_x_d, seg_y_q, seg_y_d;
    logic [SEG_W-1:0]  cand_x_q, cand_x_d, cand_y_q, cand_y_d;
    logic              border_q, border_d, wall_q, wall_d, self_q, self_d, eat_q, eat_d;
    logic              lose_q, lose_d, win_q, win_d, apple_eaten_q, apple_eaten_d;
    logic              btn_valid;
    dir_e              btn_req;
    logic [SEG_W-1:0]  next_x, next_y;
    logic              hit_border, hit_wall, hit_self, hit_eat;
    logic              collision;

    snake_collide #(.MAX_SEG(MAX_SEGMENTS)) u_collide (
        .cand_x   (next_x),
        .cand_y   (next_y),
        .seg_x    (seg_x_q),
        .seg_y    (seg_y_q),
        .length   (length_q),
        .apple_x  (applepos_x),
        .apple_y  (applepos_y),
        .wall_x   (wallpos_x),
        .wall_y   (wallpos_y),
        .border   (hit_border),
        .wall     (hit_wall),
        .self_hit (hit_self),
        .eat      (hit_eat)
    );

    // Button priority encoder and candidate head cell for the pending direction.
    always_comb begin
        btn_valid = btn_up | btn_down | btn_left | btn_right;
        if (btn_up)        btn_req = DIR_UP;
        else if (btn_down) btn_req = DIR_DOWN;
        else if (btn_left) btn_req = DIR_LEFT;
        else               btn_req = DIR_RIGHT;
        next_x = seg_x_q[SEG_W-1:0];
        next_y = seg_y_q[SEG_W-1:0];
        case (pending_dir_q)
            DIR_UP:    next_y = seg_y_q[SEG_W-1:0] - SEG_W'(GRID);
            DIR_DOWN:  next_y = seg_y_q[SEG_W-1:0] + SEG_W'(GRID);
            DIR_LEFT:  next_x = seg_x_q[SEG_W-1:0] - SEG_W'(GRID);
            DIR_RIGHT: next_x = seg_x_q[SEG_W-1:0] + SEG_W'(GRID);
            default:   next_x = seg_x_q[SEG_W-1:0];
        endcase
        collision = border_q | wall_q | self_q;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = btn_valid ? ST_RUN : ST_IDLE;
            ST_RUN:    state_d = tick ? ST_STEP : ST_RUN;
            ST_STEP:   state_d = ST_COMMIT;
            ST_COMMIT: begin
                if (collision)                    state_d = ST_DEAD;
                else if (length_d == 6'(WIN_LEN)) state_d = ST_WON;
                else                              state_d = ST_RUN;
            end
            ST_DEAD:   state_d = ST_DEAD;
            ST_WON:    state_d = ST_WON;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: direction capture, STEP evaluation, COMMIT update.
    always_comb begin
        pending_dir_d = pending_dir_q;
        head_dir_d    = head_dir_q;
        length_d      = length_q;
        seg_x_d       = seg_x_q;
        seg_y_d       = seg_y_q;
        cand_x_d      = cand_x_q;
        cand_y_d      = cand_y_q;
        border_d      = border_q;
        wall_d        = wall_q;
        self_d        = self_q;
        eat_d         = eat_q;
        lose_d        = lose_q;
        win_d         = win_q;
        apple_eaten_d = 1'b0;
        if (btn_valid && (btn_req != opposite_dir(head_dir_q))) pending_dir_d = btn_req;
        else                                                     pending_dir_d = pending_dir_q;
        case (state_q)
            ST_STEP: begin
                head_dir_d = pending_dir_q;
                cand_x_d   = next_x;
                cand_y_d   = next_y;
                border_d   = hit_border;
                wall_d     = hit_wall;
                self_d     = hit_self;
                eat_d      = hit_eat;
            end
            ST_COMMIT: begin
                if (collision) begin
                    lose_d = 1'b1;
                end else begin
                    seg_x_d = {seg_x_q[BUS_W-SEG_W-1:0], cand_x_q};
                    seg_y_d = {seg_y_q[BUS_W-SEG_W-1:0], cand_y_q};
                    if (eat_q) begin
                        length_d      = (length_q < 6'(MAX_SEGMENTS)) ? length_q + 6'd1 : length_q;
                        apple_eaten_d = 1'b1;
                    end else begin
                        length_d      = length_q;
                    end
                    win_d = (length_d == 6'(WIN_LEN));
                end
            end
            default: head_dir_d = head_dir_q;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_dir_q <= DIR_RIGHT;
            head_dir_q    <= DIR_RIGHT;
            length_q      <= 6'(INIT_LEN);
            seg_x_q       <= RST_BUS_X;
            seg_y_q       <= RST_BUS_Y;
            cand_x_q      <= 11'd0;
            cand_y_q      <= 11'd0;
            border_q      <= 1'b0;
            wall_q        <= 1'b0;
            self_q        <= 1'b0;
            eat_q         <= 1'b0;
            lose_q        <= 1'b0;
            win_q         <= 1'b0;
            apple_eaten_q <= 1'b0;
        end else begin
            pending_dir_q <= pending_dir_d;
            head_dir_q    <= head_dir_d;
            length_q      <= length_d;
            seg_x_q       <= seg_x_d;
            seg_y_q       <= seg_y_d;
            cand_x_q      <= cand_x_d;
            cand_y_q      <= cand_y_d;
            border_q      <= border_d;
            wall_q        <= wall_d;
            self_q        <= self_d;
            eat_q         <= eat_d;
            lose_q        <= lose_d;
            win_q         <= win_d;
            apple_eaten_q <= apple_eaten_d;
        end
    end

    assign snakepos_x  = seg_x_q;
    assign snakepos_y  = seg_y_q;
    assign length      = length_q;
    assign head_dir    = head_dir_q;
    assign apple_eaten = apple_eaten_q;
    assign lose        = lose_q;
    assign win         = win_q;

endmodule

// File: tb/tb_snake_engine.sv
// Directed self-checking bench for snake_engine (built with WIN_LEN=5 so the win path is reachable).
module tb_snake_engine;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         tick = 1'b0;
    logic         btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic [10:0]  applepos_x = 11'd0, applepos_y = 11'd0;
    logic [10:0]  wallpos_x = 11'd0, wallpos_y = 11'd0;
    logic [252:0] snakepos_x, snakepos_y;
    logic [5:0]   length;
    logic [1:0]   head_dir;
    logic         apple_eaten, lose, win;

    int n_cmp = 0;
    int n_bad = 0;

    snake_engine #(.WIN_LEN(5)) dut (
        .clk(clk), .rst(rst), .tick(tick),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .applepos_x(applepos_x), .applepos_y(applepos_y),
        .wallpos_x(wallpos_x), .wallpos_y(wallpos_y),
        .snakepos_x(snakepos_x), .snakepos_y(snakepos_y),
        .length(length), .head_dir(head_dir),
        .apple_eaten(apple_eaten), .lose(lose), .win(win)
    );

    always #5 clk = ~clk;

    function automatic int sx(input int i);
        return int'(snakepos_x[11*i +: 11]);
    endfunction

    function automatic int sy(input int i);
        return int'(snakepos_y[11*i +: 11]);
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        tick = 1'b0;
        {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
    endtask

    task automatic press(input logic u, input logic d, input logic l, input logic r);
        {btn_up, btn_down, btn_left, btn_right} = {u, d, l, r};
        cyc(1);
        {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
    endtask

    // One tick strobe, then wait for STEP and COMMIT so positions are settled.
    task automatic do_tick();
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        cyc(2);
    endtask

    task automatic chk_head(input string tag, input int x, input int y);
        chk({tag, ".x"}, sx(0), x);
        chk({tag, ".y"}, sy(0), y);
    endtask

    initial begin
        cyc(1);
        // 1: reset values, then ticks ignored in IDLE
        do_reset();
        chk("rst.len", int'(length), 3);
        chk("rst.dir", int'(head_dir), 3);
        chk_head("rst.s0", 688, 432);
        chk("rst.s1x", sx(1), 656);
        chk("rst.s2x", sx(2), 624);
        chk("rst.s2y", sy(2), 432);
        chk("rst.s3x", sx(3), 0);
        chk("rst.lose", int'(lose), 0);
        chk("rst.win", int'(win), 0);
        chk("rst.eat", int'(apple_eaten), 0);
        repeat (10) do_tick();
        chk_head("idle.s0", 688, 432);
        chk("idle.len", int'(length), 3);

        // 2: right then one tick
        press(1'b0, 1'b0, 1'b0, 1'b1);
        do_tick();
        chk_head("right.s0", 720, 432);
        chk("right.s1x", sx(1), 688);
        chk("right.s2x", sx(2), 656);
        chk("right.len", int'(length), 3);

        // 3: down beats left; later up is a reversal and ignored
        do_reset();
        press(1'b0, 1'b1, 1'b1, 1'b0);
        do_tick();
        chk_head("down.s0", 688, 464);
        chk("down.s1y", sy(1), 432);
        chk("down.dir", int'(head_dir), 1);
        press(1'b1, 1'b0, 1'b0, 1'b0);
        do_tick();
        chk_head("rev.s0", 688, 496);
        chk("rev.dir", int'(head_dir), 1);

        // 4: apple eaten on the second tick; pulse lasts one cycle
        do_reset();
        applepos_x = 11'd752; applepos_y = 11'd432;
        press(1'b0, 1'b0, 1'b0, 1'b1);
        do_tick();
        chk("eat1.pulse", int'(apple_eaten), 0);
        chk("eat1.len", int'(length), 3);
        do_tick();
        chk("eat2.pulse", int'(apple_eaten), 1);
        chk("eat2.len", int'(length), 4);
        chk_head("eat2.s0", 752, 432);
        chk("eat2.s3x", sx(3), 656);
        chk("eat2.s3y", sy(3), 432);
        cyc(1);
        chk("eat2.pulse_off", int'(apple_eaten), 0);
        applepos_x = 11'd0; applepos_y = 11'd0;

        // 5: wall collision freezes everything; reset restores
        do_reset();
        wallpos_x = 11'd720; wallpos_y = 11'd432;
        press(1'b0, 1'b0, 1'b0, 1'b1);
        do_tick();
        chk("wall.lose", int'(lose), 1);
        chk("wall.win", int'(win), 0);
        chk_head("wall.s0", 688, 432);
        wallpos_x = 11'd0; wallpos_y = 11'd0;
        press(1'b1, 1'b0, 1'b0, 1'b0);
        do_tick();
        chk_head("dead.s0", 688, 432);
        chk("dead.lose", int'(lose), 1);
        do_reset();
        chk("rerst.lose", int'(lose), 0);
        chk("rerst.len", int'(length), 3);
        chk_head("rerst.s0", 688, 432);

        // top border: 13 moves up reach y=16, the 14th wraps and loses
        press(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (13) do_tick();
        chk_head("top.s0", 688, 16);
        chk("top.lose", int'(lose), 0);
        do_tick();
        chk("border.lose", int'(lose), 1);
        chk_head("border.s0", 688, 16);

        // 6: two eats reach WIN_LEN=5
        do_reset();
        applepos_x = 11'd720; applepos_y = 11'd432;
        press(1'b0, 1'b0, 1'b0, 1'b1);
        do_tick();
        chk("win1.len", int'(length), 4);
        chk("win1.win", int'(win), 0);
        applepos_x = 11'd752;
        do_tick();
        chk("win2.len", int'(length), 5);
        chk("win2.win", int'(win), 1);
        chk("win2.lose", int'(lose), 0);
        chk_head("win2.s0", 752, 432);
        applepos_x = 11'd0; applepos_y = 11'd0;
        do_tick();
        chk_head("won.s0", 752, 432);
        chk("won.len", int'(length), 5);
        chk("won.win", int'(win), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
